// File: rtl/hazard_ctrl.sv
// Pipeline hazard responder: gates every pipeline register, issues bubbles on
// load-use stalls and redirects, and steps LM/SM through one transfer per cycle.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        isLW_dep,
    input  logic        redirect_ex,
    input  logic        redirect_id,
    input  logic        lmsm_start,
    input  logic [7:0]  lmsm_mask,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idrr_en,
    output logic        rrex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idrr_flush,
    output logic        rrex_flush,
    output logic        exmem_flush,
    output logic        lmsm_valid,
    output logic [2:0]  lmsm_idx,
    output logic        lmsm_last,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {StIdle, StSeq} state_e;

    state_e      state_q, state_d;
    logic [7:0]  rem_mask_q, rem_mask_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  low_idx;
    logic        one_left;

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rem_mask_q[i]) low_idx = 3'(i);
        end
        one_left = (rem_mask_q & (rem_mask_q - 8'd1)) == 8'd0;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idrr_en     = 1'b1;
        rrex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idrr_flush  = 1'b0;
        rrex_flush  = 1'b0;
        exmem_flush = 1'b0;
        lmsm_valid  = 1'b0;
        lmsm_idx    = 3'd0;
        lmsm_last   = 1'b0;
        state_d     = state_q;
        rem_mask_d  = rem_mask_q;

        if (rst) begin
            ifid_flush  = 1'b1;
            idrr_flush  = 1'b1;
            rrex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = StIdle;
            rem_mask_d  = 8'd0;
        end else if (redirect_ex) begin
            ifid_flush = 1'b1;
            idrr_flush = 1'b1;
            rrex_flush = 1'b1;
            state_d    = StIdle;
            rem_mask_d = 8'd0;
        end else if (isLW_dep) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idrr_en     = 1'b0;
            rrex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (state_q == StIdle && lmsm_start && lmsm_mask != 8'd0) begin
            // RR holds the LM/SM while a bubble enters EX ahead of the transfers
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idrr_en    = 1'b0;
            rrex_flush = 1'b1;
            rem_mask_d = lmsm_mask;
            state_d    = StSeq;
        end else if (state_q == StSeq) begin
            lmsm_valid = rem_mask_q != 8'd0;
            lmsm_idx   = low_idx;
            rem_mask_d = rem_mask_q & (rem_mask_q - 8'd1);
            if (one_left) begin
                lmsm_last = 1'b1;
                state_d   = StIdle;
            end else begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idrr_en = 1'b0;
            end
        end

        if (!rst && redirect_id && ifid_en) ifid_flush = 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rst) begin
            stall_cnt_d = 16'd0;
        end else if (!pc_en && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        rem_mask_q  <= rem_mask_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard responder for the 6-stage core: consumes the load-use stall request `isLW_dep` from the RR-stage staller and the control-flow redirects. It drives every pipeline-register enable and flush strobe, and sequences multi-register LM/SM transfers. It sits beside the pipeline registers IFID, IDRR, RREX, EXMEM and MEMWB, and is the only block allowed to gate them.

## Interface
- No parameters.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `isLW_dep` in 1: load-use stall request from the staller, valid in the same cycle.
- `redirect_ex` in 1: branch/JLR resolved taken in EX; kill the younger IF/ID/RR contents.
- `redirect_id` in 1: JAL resolved in ID; kill the IF contents.
- `lmsm_start` in 1: RR holds a valid LM or SM.
- `lmsm_mask` in 8: register-select immediate of that LM/SM; bit i selects R(i).
- `pc_en`, `ifid_en`, `idrr_en`, `rrex_en`, `exmem_en`, `memwb_en` out 1 each: pipeline register write enables.
- `ifid_flush`, `idrr_flush`, `rrex_flush`, `exmem_flush` out 1 each: load a bubble (valid=0) into that register this edge.
- `lmsm_valid` out 1: this cycle's RREX entry is one LM/SM transfer.
- `lmsm_idx` out 3: register index of that transfer.
- `lmsm_last` out 1: final transfer of the sequence.
- `stall_cnt` out 16: saturating count of frozen-front-end cycles.

## Operation
- States: IDLE, SEQ. Registered `rem_mask[7:0]`.
- Default in IDLE with no events: all enables 1, all flushes 0, lmsm outputs 0.
- Outputs are combinational from state, `rem_mask` and inputs, resolved in this priority:
  1. **`redirect_ex`**: `ifid_flush`, `idrr_flush` and `rrex_flush` = 1, all enables 1. In SEQ, go to IDLE and clear `rem_mask`. Overrides a same-cycle `isLW_dep` or `lmsm_start`.
  2. **`isLW_dep`**: `pc_en`, `ifid_en`, `idrr_en`, `rrex_en` = 0 and `exmem_flush` = 1. `memwb_en` stays 1. State and `rem_mask` hold; no transfer is issued in SEQ.
  3. **IDLE with `lmsm_start` and `lmsm_mask` != 0**:
     - `rem_mask` <= `lmsm_mask`; go to SEQ.
     - `pc_en`, `ifid_en`, `idrr_en` = 0 and `rrex_flush` = 1, so RR holds and a bubble enters EX.
  4. **SEQ transfer**:
     - `lmsm_idx` = index of the lowest set bit of `rem_mask`; `lmsm_valid` = 1; `rrex_en` = 1.
     - That bit clears at the edge.
     - If exactly one bit remains: `lmsm_last` = 1, front-end enables = 1 (RR releases), next state IDLE.
     - Otherwise `pc_en`, `ifid_en`, `idrr_en` = 0.
  5. **`redirect_id`** (only when nothing above froze IF/ID): `ifid_flush` = 1.
- `lmsm_start` with `lmsm_mask` == 0: no sequence, no stall; the instruction passes as a NOP.
- `lmsm_start` while in SEQ is ignored, since it is the same instruction still held in RR.
- `stall_cnt` increments on every cycle where `pc_en` = 0. It saturates at 16'hFFFF and is cleared only by `rst`.

## Timing
- **During `rst`:**
  - All enables = 1 and all flushes = 1.
  - `lmsm_valid`, `lmsm_last` = 0; `lmsm_idx` = 0.
  - Next state IDLE, `rem_mask` = 0, `stall_cnt` = 0.
- **Stall and flush latency:** zero-cycle combinational response to `isLW_dep` and to redirects. A `isLW_dep` held for k cycles freezes the front end for exactly k cycles.
- **LM/SM with n set bits (start seen in cycle t):**
  - Cycle t: entry bubble.
  - Cycles t+1..t+n: transfers, lowest index first.
  - RR releases at the edge ending t+n; front end is frozen for n cycles.
- **Stall during SEQ:** an `isLW_dep` inside SEQ delays the remaining transfers one cycle per stalled cycle, with indices unchanged.
- **Reset mid-SEQ:** the sequence is abandoned; no `lmsm_last` is produced.

## Test plan
- **Load-use stall:** `isLW_dep` = 1 for 2 cycles in IDLE -> `pc_en`, `ifid_en`, `idrr_en`, `rrex_en` = 0 and `exmem_flush` = 1 for exactly 2 cycles; `stall_cnt` = 2.
- **LM sequence:** `lmsm_start` with mask 8'b1010_0101 -> one bubble cycle, then `lmsm_idx` = 0, 2, 5, 7 on consecutive cycles with `lmsm_last` only on 7. Front end frozen for 4 cycles, then `pc_en` = 1.
- **Redirect during SEQ:** mask 8'hFF, `redirect_ex` in the 3rd transfer cycle -> `ifid_flush`, `idrr_flush`, `rrex_flush` = 1 that cycle; next cycle is IDLE with `lmsm_valid` = 0.
- **Stall inside SEQ:** mask 8'b0000_0110 with `isLW_dep` during the first transfer cycle -> no transfer that cycle, then idx 1, then idx 2 with `lmsm_last`.
- **Empty mask and saturation:** `lmsm_start` with mask 0 -> no stall, `lmsm_valid` never set. Separately, force `stall_cnt` to 16'hFFFE and stall 3 cycles -> count holds at 16'hFFFF.
- **Reset and priority:** `rst` mid-SEQ -> all flushes = 1, state IDLE, `stall_cnt` = 0. Simultaneous `redirect_ex` and `isLW_dep` -> flush outputs asserted and `pc_en` = 1.
